// File: rtl/hanning_pkg.sv
// hanning_pkg: shared coefficient width, coefficient type and elaboration-time table generator
package hanning_pkg;

    localparam int COEF_W = 16;

    typedef logic [COEF_W-1:0] coef_t;

    // w[n] = round(65535 * 0.5 * (1 - cos(2*pi*n/(size-1)))), evaluated at elaboration
    function automatic coef_t hanning_coef(input int n, input int size);
        real pi;
        real w;
        pi = 3.14159265358979323846;
        w = 65535.0 * 0.5 * (1.0 - $cos(2.0 * pi * real'(n) / real'(size - 1)));
        return coef_t'($rtoi(w + 0.5));
    endfunction

endpackage

// File: rtl/hanning_coef_rom.sv
// hanning_coef_rom: registered read of the lower half of the Hann window table
// Ports: clk_in (clock), addr (half-table index), coef (Q0.16 coefficient, one cycle after addr)
module hanning_coef_rom
    import hanning_pkg::*;
#(
    parameter int WINDOW_SIZE = 4096
) (
    input  logic                                clk_in,
    input  logic [$clog2(WINDOW_SIZE/2)-1:0]    addr,
    output coef_t                               coef
);

    localparam int HALF = WINDOW_SIZE / 2;

    coef_t table_w [HALF];

    for (genvar i = 0; i < HALF; i++) begin : g_tab
        assign table_w[i] = hanning_coef(i, WINDOW_SIZE);
    end

    always_ff @(posedge clk_in)
        coef <= table_w[addr];

endmodule

// File: rtl/hanning_window.sv
// hanning_window: applies a Hann window to a stream of signed samples, latency 2
// Ports: clk_in (clock), rst_in (sync active-high reset), in_sample/audio_sample_valid (input stream),
//        out_sample/hanning_sample_valid (windowed stream, value held between pulses)
// Build option: define HANNING_ROUND_EN to round half up instead of truncating.
module hanning_window
    import hanning_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 8,
    parameter int WINDOW_SIZE  = 4096
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [SAMPLE_WIDTH-1:0]  in_sample,
    input  logic                            audio_sample_valid,
    output logic signed [SAMPLE_WIDTH-1:0]  out_sample,
    output logic                            hanning_sample_valid
);

    localparam int IW = $clog2(WINDOW_SIZE);
    localparam int AW = $clog2(WINDOW_SIZE / 2);
    localparam int PW = SAMPLE_WIDTH + COEF_W + 1;
    localparam logic [IW-1:0] LAST = IW'(WINDOW_SIZE - 1);
    localparam logic [IW-1:0] HALF = IW'(WINDOW_SIZE / 2);

    logic [IW-1:0]                  n;
    logic [IW-1:0]                  mirror;
    logic                           v1;
    logic signed [SAMPLE_WIDTH-1:0] sample_q;
    coef_t                          coef_q;
    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           prod_adj;

    // upper half of the window reuses the lower half: w[n] = w[N-1-n]
    assign mirror = (n >= HALF) ? LAST - n : n;

    hanning_coef_rom #(.WINDOW_SIZE(WINDOW_SIZE)) u_rom (
        .clk_in (clk_in),
        .addr   (mirror[AW-1:0]),
        .coef   (coef_q)
    );

    // coefficient is zero-extended so it stays non-negative in the signed product
    assign prod = PW'(sample_q) * PW'($signed({1'b0, coef_q}));

`ifdef HANNING_ROUND_EN
    assign prod_adj = prod + PW'(1 << 15);
`else
    assign prod_adj = prod;
`endif

    always_ff @(posedge clk_in)
        sample_q <= in_sample;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            n                    <= '0;
            v1                   <= 1'b0;
            hanning_sample_valid <= 1'b0;
            out_sample           <= '0;
        end else begin
            if (audio_sample_valid)
                n <= (n == LAST) ? '0 : n + 1'b1;
            v1                   <= audio_sample_valid;
            hanning_sample_valid <= v1;
            if (v1)
                out_sample <= SAMPLE_WIDTH'(prod_adj >>> 16);
        end
    end

endmodule

// File: tb/tb_hanning_window.sv
// tb_hanning_window: randomized scoreboard bench for hanning_window against a real-arithmetic model
module tb_hanning_window;

    localparam int N  = 4096;
    localparam int SW = 8;
`ifdef HANNING_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic                  audio_sample_valid = 1'b0;
    logic signed [SW-1:0]  in_sample = '0;
    logic signed [SW-1:0]  out_sample;
    logic                  hanning_sample_valid;

    hanning_window #(.SAMPLE_WIDTH(SW), .WINDOW_SIZE(N)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .in_sample            (in_sample),
        .audio_sample_valid   (audio_sample_valid),
        .out_sample           (out_sample),
        .hanning_sample_valid (hanning_sample_valid)
    );

    always #5 clk_in = ~clk_in;

    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   model_n = 0;
    int   rst_eff = 1 << 30;
    bit   mon_on = 1'b0;
    int   last = 0;
    int   obs [8192];
    int   obs_cnt = 0;
    int   in_cnt = 0;
    int   out_cnt = 0;
    exp_t sb [$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic fail(input string name, input int act, input int exp);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        if (act != exp) fail(name, act, exp);
        else checks++;
    endtask

    function automatic int w_of(input int n);
        int  k;
        real c;
        k = (n < N / 2) ? n : N - 1 - n;
        c = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N - 1)));
        return $rtoi($floor(c + 0.5));
    endfunction

    function automatic int exp_of(input int x, input int n);
        longint p;
        p = longint'(x) * longint'(w_of(n));
        if (RND) p = p + 32768;
        return int'(p >>> 16);
    endfunction

    function automatic int rnd_s();
        return int'($urandom_range(255)) - 128;
    endfunction

    task automatic drive(input int v, input bit val, input bit r);
        @(posedge clk_in);
        #2;
        in_sample          = SW'(v);
        audio_sample_valid = val;
        rst_in             = r;
        if (r) begin
            model_n = 0;
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
            rst_eff = cyc + 1;
        end else if (val) begin
            sb.push_back('{exp_of(v, model_n), cyc + 2});
            model_n = (model_n + 1) % N;
            in_cnt++;
        end
    endtask

    task automatic drain();
        drive(0, 1'b0, 1'b0);
        repeat (4) @(posedge clk_in);
        @(negedge clk_in);
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        drain();
        drive(0, 1'b0, 1'b1);
        obs_cnt = 0;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (cyc == rst_eff) begin
            mon_on = 1'b1;
            last   = 0;
            chk("rst_out", int'(out_sample), 0);
        end
        if (mon_on) begin
            if (cyc == rst_eff || cyc == rst_eff + 1)
                chk("rst_valid", int'(hanning_sample_valid), 0);
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                fail("missing_valid", cyc, e.due);
            end
            if (hanning_sample_valid) begin
                out_cnt++;
                if (sb.size() == 0) fail("unexpected_valid", int'(out_sample), 0);
                else begin
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("out_sample", int'(out_sample), e.val);
                end
                last = int'(out_sample);
                if (obs_cnt < 8192) obs[obs_cnt] = int'(out_sample);
                obs_cnt++;
            end else begin
                chk("hold", int'(out_sample), last);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

    initial begin
        drive(0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b1);
        obs_cnt = 0;
        for (int i = 0; i < 4100; i++) drive(100, 1'b1, 1'b0);
        drain();
        chk("n0", obs[0], 0);
        chk("n1024", obs[1024], 50);
        chk("n2048", obs[2048], RND ? 100 : 99);
        chk("n4095", obs[4095], 0);
        chk("wrap_w0", obs[4096], 0);
        chk("wrap_eq", obs[4097], obs[1]);
        for (int i = 0; i < N / 2; i++) chk("symmetry", obs[i], obs[N - 1 - i]);

        do_reset();
        for (int i = 0; i < 2048; i++) drive(rnd_s(), 1'b1, 1'b0);
        drive(-128, 1'b1, 1'b0);
        drain();
        chk("min_2048", obs[2048], -128);

        do_reset();
        for (int i = 0; i < 2048; i++) drive(rnd_s(), 1'b1, 1'b0);
        drive(127, 1'b1, 1'b0);
        drain();
        chk("max_2048", obs[2048], RND ? 127 : 126);

        do_reset();
        in_cnt  = 0;
        out_cnt = 0;
        for (int i = 0; i < 600; i++) drive(rnd_s(), (i % 3) == 0, 1'b0);
        drain();
        chk("gap_count", out_cnt, in_cnt);

        do_reset();
        for (int i = 0; i < 500; i++) drive(rnd_s(), 1'b1, 1'b0);
        drive(rnd_s(), 1'b1, 1'b1);
        drive(rnd_s(), 1'b1, 1'b0);
        obs_cnt = 0;
        for (int i = 0; i < 20; i++) drive(rnd_s(), 1'b1, 1'b0);
        drain();
        chk("post_rst_w0", obs[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hanning_window.md
HANNING_WINDOW -- requirements
Module: hanning_window

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 8, giving the signed sample width in bits (positional parameter 1).
REQ-002 SHALL have parameter WINDOW_SIZE, default 4096, giving the window length N (positional parameter 2); N SHALL be even and at least 4.
REQ-003 SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1, reset; reset is synchronous and active-high.
REQ-005 SHALL have port in_sample, input, SAMPLE_WIDTH, signed two's-complement audio sample.
REQ-006 SHALL have port audio_sample_valid, input, 1, which qualifies in_sample for one cycle.
REQ-007 SHALL have port out_sample, output, SAMPLE_WIDTH, signed windowed sample.
REQ-008 SHALL have port hanning_sample_valid, output, 1, which qualifies out_sample for one cycle.

Function
REQ-009 SHALL keep sample index n, 0..N-1, which advances by 1 on each cycle with audio_sample_valid=1 and holds otherwise.
REQ-010 SHALL wrap n from N-1 to 0 with no gap, so consecutive frames are contiguous.
REQ-011 SHALL use coefficient w[n] = round(65535 * 0.5 * (1 - cos(2*pi*n/(N-1)))) as unsigned 16 bits (Q0.16).
REQ-012 SHALL satisfy w[0] = w[N-1] = 0 and symmetry w[n] = w[N-1-n].
REQ-013 SHALL store only entries 0..N/2-1 and address n >= N/2 as N-1-n.
REQ-014 SHALL compute product = in_sample * w[n] as a signed (SAMPLE_WIDTH+17)-bit value, with the coefficient zero-extended to signed.
REQ-015 SHALL set out_sample = product arithmetically shifted right by 16; by construction |out_sample| <= |in_sample|, so no saturation logic is needed.
REQ-016 SHALL have fixed latency 2: a sample accepted in cycle t appears on out_sample with hanning_sample_valid=1 in cycle t+2.
REQ-017 SHALL accept samples back-to-back every cycle with no backpressure; throughput is 1 sample per cycle.
REQ-018 SHALL keep hanning_sample_valid as a one-cycle pulse per accepted sample, never asserted otherwise.
REQ-019 SHALL hold out_sample at its last value while hanning_sample_valid=0.

Reset
REQ-020 SHALL, on rst_in=1, clear on the next edge: n=0, both pipeline valid stages=0, out_sample=0, hanning_sample_valid=0.
REQ-021 SHALL discard any sample presented in a cycle with rst_in=1.
REQ-022 SHALL, after reset mid-frame, window the next accepted sample with w[0]; in-flight samples are dropped and produce no valid.

Configuration
REQ-023 SHALL, with macro HANNING_ROUND_EN defined, add 2^15 to product before the shift (round half up).
REQ-024 SHALL, without HANNING_ROUND_EN, truncate (floor) with no rounding adder; latency is identical in both builds.

Structure
REQ-025 SHALL place in shared package hanning_pkg: the coefficient width constant (16), the coefficient typedef, and the constant function that generates the table at elaboration from real-valued $cos.
REQ-026 SHALL contain one sub-module, hanning_coef_rom (WINDOW_SIZE parameter), a registered read of N/2 entries initialised from the package function.
REQ-027 SHALL consist of the index counter, mirror addressing, multiplier and output register in hanning_window itself.

Verification
REQ-028 Bench SHALL drive constant in_sample=100 valid every cycle for 4096 cycles -> outputs for n=0 and n=4095 are 0; n=1024 is 50; n=2048 is 99 (truncate) or 100 (HANNING_ROUND_EN).
REQ-029 Bench SHALL drive in_sample=-128 at n=2048 -> out_sample=-128 in both builds; in_sample=127 at n=2048 -> 126 (truncate) or 127 (round).
REQ-030 Bench SHALL insert gaps (valid 1 of every 3 cycles) -> each output arrives exactly 2 cycles after its input, index advances only on valid, and the valid count equals the input count.
REQ-031 Bench SHALL feed 4100 consecutive valids -> sample 4096 uses w[0] (output 0), and sample 4097 equals sample 1's output.
REQ-032 Bench SHALL pulse rst_in at n=500 with valids in flight -> no hanning_sample_valid for 2 cycles, outputs 0, and the next accepted sample uses w[0].
REQ-033 Bench SHALL check symmetry: outputs for n and 4095-n are equal for a constant input, over all n.
